fetch_decode: RTL and testbench
===============================

FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 program_byte  input  8  asynchronous ROM data at rom_addr; [7:4]=opcode, [3:0]=operand.
REQ-004 c_in  input  1  carry from ALU.
REQ-005 z_in  input  1  zero from ALU.
REQ-006 rom_addr  output  8  program counter value.
REQ-007 oprnd  output  4  operand nibble of IR; drives datapath bus1 input.
REQ-008 sel  output  3  ALU select: 0 pass A, 1 sub, 2 pass B, 3 add, 4 nand.
REQ-009 accu_en, bus1_en, bus2_en  output  1 each  datapath enables.
REQ-010 c_flag, z_flag  output  1 each  registered flags.
REQ-011 state  output  2  FSM state: 0 FETCH, 1 EXEC, 2 ADDR, 3 HALT.

Function
REQ-012 FETCH: rom_addr=PC; on edge IR<=program_byte, PC<=PC+1; next state ADDR if opcode is a jump, HALT if 0xF, else EXEC.
REQ-013 EXEC: controls decoded from IR for exactly one cycle; next state FETCH.
REQ-014 Opcodes: 0 NOP; 1 LIT (sel2, bus1_en, accu_en); 2 ADD (sel3, bus1_en, accu_en); 3 SUB (sel1, bus1_en, accu_en); 4 NAND (sel4, bus1_en, accu_en); 5 CMP (sel1, bus1_en, accu_en=0); 6 OUT (sel0, bus2_en); 7 JMP; 8 JC; 9 JZ; A–E NOP; F HALT.
REQ-015 Outside EXEC: sel=0, accu_en=bus1_en=bus2_en=0.
REQ-016 Flags: at the edge ending EXEC, c_flag<=c_in and z_flag<=z_in for ADD, SUB, CMP only; other opcodes hold flags.
REQ-017 ADDR: rom_addr=PC (target byte); on edge PC<=program_byte if jump taken, else PC<=PC+1; next state FETCH.
REQ-018 JMP always taken; JC taken when c_flag=1; JZ taken when z_flag=1; flags are the registered values, not c_in/z_in.
REQ-019 Latency: ALU/OUT/NOP instruction = 2 cycles; jump = 2 cycles, consumes 2 bytes.
REQ-020 PC is 8-bit, wraps 0xFF->0x00 both on increment and when fetching a jump target at 0xFF.
REQ-021 HALT: all controls deasserted, PC and flags frozen; leaves only on reset.
REQ-022 oprnd = IR[3:0] in every state.

Reset
REQ-023 On reset: PC=0x00, IR=0x00, c_flag=z_flag=0, state=FETCH, sel=0, all enables 0.
REQ-024 Reset asserted mid-instruction (any state) aborts it; no accumulator write or flag update occurs on that edge.
REQ-025 After reset deassertion, first rising edge fetches address 0x00.

Configuration
REQ-026 Macro FETCH_COND_JUMP_EN: defined -> JC/JZ behave per REQ-018.
REQ-027 Undefined -> opcodes 8 and 9 decode as one-byte NOPs (FETCH->EXEC, no ADDR cycle); JMP unaffected.

Structure
REQ-028 Package fetch_decode_pkg holds opcode constants, state encoding, ALU sel codes.
REQ-029 Sub-module program_counter (8-bit register with inc/load/hold, async reset); FSM and decoder in fetch_decode.

Verification
REQ-030 Reset, ROM {0x15,0x23} -> cycle 1: LIT: sel=2, bus1_en=1, accu_en=1, oprnd=5; cycle 3: ADD: sel=3, oprnd=3; rom_addr 0->1->1->2->2.
REQ-031 ROM@0 {0x70,0x40} -> state FETCH,ADDR,FETCH; rom_addr 0x00,0x01,0x40; no enables asserted.
REQ-032 CMP with c_in=1,z_in=0 then JC 0x20 -> taken (PC=0x20); repeat with c_in=0 -> PC=0x03; with macro undefined -> opcode 8 is NOP, PC=0x02.
REQ-033 PC at 0xFF fetching NOP -> next rom_addr=0x00.
REQ-034 Opcode 0xF -> state=3, rom_addr frozen for 10 cycles, enables 0; reset -> state=0, rom_addr=0.
REQ-035 Reset pulse during EXEC of ADD -> accu_en drops asynchronously, flags stay 0, restart at 0x00.

Source files
------------

// File: rtl/fetch_decode_pkg.sv
// Shared opcode, state and ALU-select definitions for the fetch/decode controller.
// Build macro FETCH_COND_JUMP_EN enables the conditional jumps JC/JZ.
package fetch_decode_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_ADDR  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LIT  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_NAND = 4'h4;
  localparam logic [3:0] OP_CMP  = 4'h5;
  localparam logic [3:0] OP_OUT  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JC   = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] SEL_PASS_A = 3'd0;
  localparam logic [2:0] SEL_SUB    = 3'd1;
  localparam logic [2:0] SEL_PASS_B = 3'd2;
  localparam logic [2:0] SEL_ADD    = 3'd3;
  localparam logic [2:0] SEL_NAND   = 3'd4;

  typedef struct packed {
    logic [2:0] sel;
    logic       accu_en;
    logic       bus1_en;
    logic       bus2_en;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{SEL_PASS_A, 1'b0, 1'b0, 1'b0};

  function automatic ctrl_t decode_ctrl(input logic [3:0] op);
    ctrl_t c;
    c = CTRL_IDLE;
    case (op)
      OP_LIT:  c = '{SEL_PASS_B, 1'b1, 1'b1, 1'b0};
      OP_ADD:  c = '{SEL_ADD,    1'b1, 1'b1, 1'b0};
      OP_SUB:  c = '{SEL_SUB,    1'b1, 1'b1, 1'b0};
      OP_NAND: c = '{SEL_NAND,   1'b1, 1'b1, 1'b0};
      OP_CMP:  c = '{SEL_SUB,    1'b0, 1'b1, 1'b0};
      OP_OUT:  c = '{SEL_PASS_A, 1'b0, 1'b0, 1'b1};
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

  // Two-byte opcodes: these take the ADDR cycle to consume their target byte.
  function automatic logic is_jump(input logic [3:0] op);
`ifdef FETCH_COND_JUMP_EN
    return (op == OP_JMP) || (op == OP_JC) || (op == OP_JZ);
`else
    return (op == OP_JMP);
`endif
  endfunction

  function automatic logic updates_flags(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// ROM / ALU / datapath-control bundle between the controller (master) and its datapath (slave).
interface fetch_decode_if;
  logic [7:0] program_byte;
  logic       c_in;
  logic       z_in;
  logic [7:0] rom_addr;
  logic [3:0] oprnd;
  logic [2:0] sel;
  logic       accu_en;
  logic       bus1_en;
  logic       bus2_en;
  logic       c_flag;
  logic       z_flag;
  logic [1:0] state;

  modport master (
    input  program_byte, c_in, z_in,
    output rom_addr, oprnd, sel, accu_en, bus1_en, bus2_en, c_flag, z_flag, state
  );

  modport slave (
    output program_byte, c_in, z_in,
    input  rom_addr, oprnd, sel, accu_en, bus1_en, bus2_en, c_flag, z_flag, state
  );
endinterface

// File: rtl/fetch_decode_program_counter.sv
// 8-bit program counter: load has priority over increment, otherwise hold; wraps naturally.
module program_counter (
  input  logic       CLK,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] pc
);

  // PC register with asynchronous clear
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pc <= 8'h00;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 8'd1;
    end else begin
      pc <= pc;
    end
  end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode controller: FETCH/EXEC/ADDR/HALT sequencer with registered datapath controls.
// Build macro FETCH_COND_JUMP_EN: defined -> JC/JZ are two-byte conditional jumps, else NOPs.
module fetch_decode
  import fetch_decode_pkg::*;
(
  input  logic          CLK,
  input  logic          reset,
  fetch_decode_if.master bus
);

  state_e     state_r;
  logic [7:0] ir_r;
  ctrl_t      ctrl_r;
  logic       c_flag_r;
  logic       z_flag_r;
  logic [7:0] pc_s;
  logic [3:0] opcode_s;
  logic [3:0] fetch_op_s;
  logic       jump_taken_s;
  logic       pc_inc_s;
  logic       pc_load_s;

  assign opcode_s   = ir_r[7:4];
  assign fetch_op_s = bus.program_byte[7:4];

  // Jump condition evaluated against the registered flags only
  always_comb begin
    jump_taken_s = 1'b0;
    case (opcode_s)
      OP_JMP:  jump_taken_s = 1'b1;
`ifdef FETCH_COND_JUMP_EN
      OP_JC:   jump_taken_s = c_flag_r;
      OP_JZ:   jump_taken_s = z_flag_r;
`endif
      default: jump_taken_s = 1'b0;
    endcase
  end

  // PC step selection per state
  always_comb begin
    pc_inc_s  = 1'b0;
    pc_load_s = 1'b0;
    case (state_r)
      ST_FETCH: pc_inc_s = 1'b1;
      ST_ADDR: begin
        if (jump_taken_s) begin
          pc_load_s = 1'b1;
        end else begin
          pc_inc_s  = 1'b1;
        end
      end
      default: begin
        pc_inc_s  = 1'b0;
        pc_load_s = 1'b0;
      end
    endcase
  end

  program_counter u_pc (
    .CLK      (CLK),
    .reset    (reset),
    .inc      (pc_inc_s),
    .load     (pc_load_s),
    .load_val (bus.program_byte),
    .pc       (pc_s)
  );

  // Sequencer; controls are decoded from the fetched byte so they are live for the EXEC cycle only
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r  <= ST_FETCH;
      ir_r     <= 8'h00;
      ctrl_r   <= CTRL_IDLE;
      c_flag_r <= 1'b0;
      z_flag_r <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          ir_r <= bus.program_byte;
          if (fetch_op_s == OP_HALT) begin
            state_r <= ST_HALT;
            ctrl_r  <= CTRL_IDLE;
          end else if (is_jump(fetch_op_s)) begin
            state_r <= ST_ADDR;
            ctrl_r  <= CTRL_IDLE;
          end else begin
            state_r <= ST_EXEC;
            ctrl_r  <= decode_ctrl(fetch_op_s);
          end
        end
        ST_EXEC: begin
          state_r <= ST_FETCH;
          ctrl_r  <= CTRL_IDLE;
          if (updates_flags(opcode_s)) begin
            c_flag_r <= bus.c_in;
            z_flag_r <= bus.z_in;
          end else begin
            c_flag_r <= c_flag_r;
            z_flag_r <= z_flag_r;
          end
        end
        ST_ADDR: begin
          state_r <= ST_FETCH;
          ctrl_r  <= CTRL_IDLE;
        end
        ST_HALT: begin
          state_r <= ST_HALT;
          ctrl_r  <= CTRL_IDLE;
        end
        default: begin
          state_r <= ST_FETCH;
          ctrl_r  <= CTRL_IDLE;
        end
      endcase
    end
  end

  assign bus.rom_addr = pc_s;
  assign bus.oprnd    = ir_r[3:0];
  assign bus.sel      = ctrl_r.sel;
  assign bus.accu_en  = ctrl_r.accu_en;
  assign bus.bus1_en  = ctrl_r.bus1_en;
  assign bus.bus2_en  = ctrl_r.bus2_en;
  assign bus.c_flag   = c_flag_r;
  assign bus.z_flag   = z_flag_r;
  assign bus.state    = state_r;

endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboard bench for fetch_decode: directed ROM programs, per-cycle expected outputs queued and
// compared by an independent negedge monitor. Honors FETCH_COND_JUMP_EN for jump expectations.
module tb_fetch_decode;

  localparam logic [1:0] F = 2'd0;
  localparam logic [1:0] E = 2'd1;
  localparam logic [1:0] A = 2'd2;
  localparam logic [1:0] H = 2'd3;

  typedef struct {
    string       name;
    logic [21:0] vec;
  } exp_t;

  logic       CLK;
  logic       reset;
  logic [7:0] rom [0:255];
  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;

  fetch_decode_if bus();

  fetch_decode dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.program_byte = rom[bus.rom_addr];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // {state, rom_addr, sel, {accu_en,bus1_en,bus2_en}, oprnd, {c_flag,z_flag}}
  function automatic logic [21:0] pack_v(logic [1:0] st, logic [7:0] a, logic [2:0] s,
                                         logic [2:0] en, logic [3:0] o, logic [1:0] f);
    return {st, a, s, en, o, f};
  endfunction

  function automatic logic [21:0] dut_v();
    return {bus.state, bus.rom_addr, bus.sel, bus.accu_en, bus.bus1_en, bus.bus2_en,
            bus.oprnd, bus.c_flag, bus.z_flag};
  endfunction

  function automatic void check(string name, logic [21:0] act, logic [21:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got st=%0d addr=%h sel=%0d en=%b op=%h fl=%b, required st=%0d addr=%h sel=%0d en=%b op=%h fl=%b",
               name, act[21:20], act[19:12], act[11:9], act[8:6], act[5:2], act[1:0],
               req[21:20], req[19:12], req[11:9], req[8:6], req[5:2], req[1:0]);
    end
  endfunction

  function automatic void ex(string name, logic [1:0] st, logic [7:0] a, logic [2:0] s,
                             logic [2:0] en, logic [3:0] o, logic [1:0] f);
    exp_t e;
    e.name = name;
    e.vec  = pack_v(st, a, s, en, o, f);
    exp_q.push_back(e);
  endfunction

  // Monitor: one queued expectation per out-of-reset cycle
  always @(negedge CLK) begin
    if (!reset && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, dut_v(), e.vec);
    end
  end

  task automatic do_reset();
    @(posedge CLK);
    #2 reset = 1'b1;
    #1 check("reset_state", dut_v(), pack_v(F, 8'h00, 3'd0, 3'b000, 4'h0, 2'b00));
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic go();
    @(posedge CLK);
    #2 reset = 1'b0;
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d entries left, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    reset    = 1'b1;
    bus.c_in = 1'b0;
    bus.z_in = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;

    // LIT 5 then ADD 3; ADD latches flags, LIT holds them
    do_reset();
    rom[0] = 8'h15; rom[1] = 8'h23;
    bus.c_in = 1'b1; bus.z_in = 1'b1;
    ex("lit_fetch", F, 8'h00, 3'd0, 3'b000, 4'h0, 2'b00);
    ex("lit_exec",  E, 8'h01, 3'd2, 3'b110, 4'h5, 2'b00);
    ex("add_fetch", F, 8'h01, 3'd0, 3'b000, 4'h5, 2'b00);
    ex("add_exec",  E, 8'h02, 3'd3, 3'b110, 4'h3, 2'b00);
    ex("add_flags", F, 8'h02, 3'd0, 3'b000, 4'h3, 2'b11);
    ex("nop_exec",  E, 8'h03, 3'd0, 3'b000, 4'h0, 2'b11);
    go(); drain("lit_add");

    // JMP 0x40
    do_reset();
    rom[0] = 8'h70; rom[1] = 8'h40;
    bus.c_in = 1'b0; bus.z_in = 1'b0;
    ex("jmp_fetch",  F, 8'h00, 3'd0, 3'b000, 4'h0, 2'b00);
    ex("jmp_addr",   A, 8'h01, 3'd0, 3'b000, 4'h0, 2'b00);
    ex("jmp_target", F, 8'h40, 3'd0, 3'b000, 4'h0, 2'b00);
    ex("jmp_exec",   E, 8'h41, 3'd0, 3'b000, 4'h0, 2'b00);
    go(); drain("jmp");

    // CMP with carry set, then JC 0x20
    do_reset();
    rom[0] = 8'h50; rom[1] = 8'h80; rom[2] = 8'h20;
    bus.c_in = 1'b1; bus.z_in = 1'b0;
    ex("cmp_fetch", F, 8'h00, 3'd0, 3'b000, 4'h0, 2'b00);
    ex("cmp_exec",  E, 8'h01, 3'd1, 3'b010, 4'h0, 2'b00);
    ex("jc_fetch",  F, 8'h01, 3'd0, 3'b000, 4'h0, 2'b10);
`ifdef FETCH_COND_JUMP_EN
    ex("jc_addr",   A, 8'h02, 3'd0, 3'b000, 4'h0, 2'b10);
    ex("jc_taken",  F, 8'h20, 3'd0, 3'b000, 4'h0, 2'b10);
`else
    ex("jc_nop",    E, 8'h02, 3'd0, 3'b000, 4'h0, 2'b10);
    ex("jc_next",   F, 8'h02, 3'd0, 3'b000, 4'h0, 2'b10);
`endif
    go(); drain("jc_set");

    // CMP with carry clear, then JC 0x20 not taken
    do_reset();
    rom[0] = 8'h50; rom[1] = 8'h80; rom[2] = 8'h20;
    bus.c_in = 1'b0; bus.z_in = 1'b0;
    ex("cmp2_fetch", F, 8'h00, 3'd0, 3'b000, 4'h0, 2'b00);
    ex("cmp2_exec",  E, 8'h01, 3'd1, 3'b010, 4'h0, 2'b00);
    ex("jc2_fetch",  F, 8'h01, 3'd0, 3'b000, 4'h0, 2'b00);
`ifdef FETCH_COND_JUMP_EN
    ex("jc2_addr",   A, 8'h02, 3'd0, 3'b000, 4'h0, 2'b00);
    ex("jc2_skip",   F, 8'h03, 3'd0, 3'b000, 4'h0, 2'b00);
`else
    ex("jc2_nop",    E, 8'h02, 3'd0, 3'b000, 4'h0, 2'b00);
    ex("jc2_next",   F, 8'h02, 3'd0, 3'b000, 4'h0, 2'b00);
`endif
    go(); drain("jc_clear");

    // SUB with zero set, then JZ 0x55
    do_reset();
    rom[0] = 8'h30; rom[1] = 8'h90; rom[2] = 8'h55;
    bus.c_in = 1'b0; bus.z_in = 1'b1;
    ex("sub_fetch", F, 8'h00, 3'd0, 3'b000, 4'h0, 2'b00);
    ex("sub_exec",  E, 8'h01, 3'd1, 3'b110, 4'h0, 2'b00);
    ex("jz_fetch",  F, 8'h01, 3'd0, 3'b000, 4'h0, 2'b01);
`ifdef FETCH_COND_JUMP_EN
    ex("jz_addr",   A, 8'h02, 3'd0, 3'b000, 4'h0, 2'b01);
    ex("jz_taken",  F, 8'h55, 3'd0, 3'b000, 4'h0, 2'b01);
`else
    ex("jz_nop",    E, 8'h02, 3'd0, 3'b000, 4'h0, 2'b01);
    ex("jz_next",   F, 8'h02, 3'd0, 3'b000, 4'h0, 2'b01);
`endif
    go(); drain("jz");

    // Jump to 0xFF, NOP there, PC wraps to 0x00
    do_reset();
    rom[0] = 8'h70; rom[1] = 8'hFF;
    bus.c_in = 1'b0; bus.z_in = 1'b0;
    ex("wrap_fetch0", F, 8'h00, 3'd0, 3'b000, 4'h0, 2'b00);
    ex("wrap_addr",   A, 8'h01, 3'd0, 3'b000, 4'h0, 2'b00);
    ex("wrap_fetch",  F, 8'hFF, 3'd0, 3'b000, 4'h0, 2'b00);
    ex("wrap_exec",   E, 8'h00, 3'd0, 3'b000, 4'h0, 2'b00);
    ex("wrap_next",   F, 8'h00, 3'd0, 3'b000, 4'h0, 2'b00);
    go(); drain("wrap");

    // LIT 2 then HALT; frozen for 10 cycles
    do_reset();
    rom[0] = 8'h12; rom[1] = 8'hF7;
    bus.c_in = 1'b1; bus.z_in = 1'b1;
    ex("h_lit_fetch", F, 8'h00, 3'd0, 3'b000, 4'h0, 2'b00);
    ex("h_lit_exec",  E, 8'h01, 3'd2, 3'b110, 4'h2, 2'b00);
    ex("halt_fetch",  F, 8'h01, 3'd0, 3'b000, 4'h2, 2'b00);
    for (int i = 0; i < 10; i++) ex("halt_hold", H, 8'h02, 3'd0, 3'b000, 4'h7, 2'b00);
    go(); drain("halt");

    // Reset pulse during ADD's EXEC aborts it
    do_reset();
    rom[0] = 8'h2A;
    bus.c_in = 1'b1; bus.z_in = 1'b1;
    ex("abort_fetch", F, 8'h00, 3'd0, 3'b000, 4'h0, 2'b00);
    go();
    @(posedge CLK);
    #1 check("abort_add_live", dut_v(), pack_v(E, 8'h01, 3'd3, 3'b110, 4'hA, 2'b00));
    #1 reset = 1'b1;
    #1 check("abort_async", dut_v(), pack_v(F, 8'h00, 3'd0, 3'b000, 4'h0, 2'b00));
    @(posedge CLK);
    #1 check("abort_held", dut_v(), pack_v(F, 8'h00, 3'd0, 3'b000, 4'h0, 2'b00));
    ex("restart_fetch", F, 8'h00, 3'd0, 3'b000, 4'h0, 2'b00);
    ex("restart_exec",  E, 8'h01, 3'd3, 3'b110, 4'hA, 2'b00);
    ex("restart_flags", F, 8'h01, 3'd0, 3'b000, 4'hA, 2'b11);
    #1 reset = 1'b0;
    drain("restart");

    do_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
